multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter XLEN, default 64, register data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, at least 4; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 clk  input  1  single clock, all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-008 rd_data  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-009 rd_pend  output  NRD  scoreboard pending bit of the register addressed by each read port.
REQ-010 wr_en  input  NWR  per-port write enable.
REQ-011 wr_addr  input  NWR*AW  write addresses.
REQ-012 wr_data  input  NWR*XLEN  write data.
REQ-013 alloc_en  input  1  marks alloc_addr as pending (result in flight).
REQ-014 alloc_addr  input  AW  register to mark pending.
REQ-015 clr_req  input  1  one-cycle request to start a sequential clear of all registers.
REQ-016 clr_busy  output  1  high while the clear sequence runs.

Function
REQ-017 Reads SHALL be combinational: rd_data[k] = registers[rd_addr[k]]; address 0 SHALL always read 0.
REQ-018 A write on port j with wr_en[j]=1 and wr_addr[j]!=0 SHALL update the register at the next rising edge; writes to address 0 SHALL be dropped.
REQ-019 When two or more enabled write ports target the same address in one cycle, the highest-numbered port SHALL win.
REQ-020 Each nonzero register SHALL have one pend bit; alloc_en with alloc_addr!=0 SHALL set it at the next edge.
REQ-021 Any accepted write to a register SHALL clear its pend bit at the next edge.
REQ-022 When an alloc and a write target the same register in the same cycle, alloc SHALL win and the pend bit SHALL end set, while the data write still completes.
REQ-023 rd_pend[k] SHALL equal the current pend bit of rd_addr[k], and SHALL be 0 for address 0.
REQ-024 The clear FSM SHALL have states IDLE and CLEAR; in IDLE, clr_req=1 SHALL move it to CLEAR with index 1.
REQ-025 In CLEAR, each cycle SHALL zero registers[index] and its pend bit, then increment index; after index NREGS-1 it SHALL return to IDLE, so CLEAR lasts NREGS-1 cycles.
REQ-026 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-027 During CLEAR, writes and allocs SHALL be dropped, clr_req SHALL be ignored, and all rd_data SHALL read 0 while rd_pend reads 0.

Reset
REQ-028 rst=1 SHALL asynchronously zero all registers and pend bits, force the FSM to IDLE with index 0, and drive clr_busy=0.
REQ-029 Immediately after reset, rd_data SHALL be all 0 and rd_pend SHALL be all 0.
REQ-030 Reset asserted mid-CLEAR SHALL abort the sequence; no further clear cycles SHALL occur after rst deasserts.

Configuration
REQ-031 With macro MULTIPORT_REGFILE_BYPASS_EN defined, a read whose address matches an enabled, nonzero same-cycle write SHALL return that write's data, using the REQ-019 winner.
REQ-032 In that bypass case rd_pend SHALL read 0 unless alloc targets the same register in the same cycle.
REQ-033 Without MULTIPORT_REGFILE_BYPASS_EN, reads SHALL return the pre-edge stored value, with no forwarding logic present.
REQ-034 The clear FSM SHALL take precedence over bypass: during CLEAR, reads return 0 regardless of the macro.

Verification
REQ-035 Write x5=0x1122334455667788 on port 0, then read x5 on port 1 next cycle -> 0x1122334455667788; write x0=0xFFFF then read x0 -> 0.
REQ-036 Same cycle, port 0 writes x7=0xA and port 1 writes x7=0xB -> x7 reads 0xB next cycle.
REQ-037 Alloc x9, then read x9 -> rd_pend=1; write x9=0x3 -> next cycle rd_pend=0; same-cycle alloc and write to x9 -> rd_pend=1 and data=0x3.
REQ-038 Fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high for exactly 31 cycles, a write issued during CLEAR is lost, and all registers read 0 afterwards.
REQ-039 Assert rst at clear cycle 10 -> clr_busy drops immediately and all registers read 0.
REQ-040 Bypass build: write x3=0x55 and read x3 in the same cycle -> 0x55; non-bypass build -> old value 0.

Source files
------------

// File: rtl/multiport_regfile.sv
// multiport_regfile: register file with NRD combinational read ports and
// NWR write ports. It also keeps a pending-result scoreboard bit per
// register and has a sequential clear FSM. Register 0 always reads 0.
// Optional feature: define MULTIPORT_REGFILE_BYPASS_EN to forward
// same-cycle write data to the read ports.
module multiport_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                clr_req,
    output logic                clr_busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t                      state, state_nxt;
    logic [AW-1:0]               clr_idx;
    logic [NREGS-1:0][XLEN-1:0]  regs;
    logic [NREGS-1:0]            pend;

    // Packed per-port views of the flat port vectors
    logic [NRD-1:0][AW-1:0]      ra;
    logic [NRD-1:0][XLEN-1:0]    rdv;
    logic [NWR-1:0][AW-1:0]      wa;
    logic [NWR-1:0][XLEN-1:0]    wd;

    assign ra      = rd_addr;
    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign rd_data = rdv;

    // Clear FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Clear FSM next state: leave CLEAR once the last register is zeroed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        clr_busy = (state == CLEAR);
    end

    // Clear index: starts at 1 because register 0 is hardwired to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        clr_idx <= '0;
        else if (state == IDLE)         clr_idx <= clr_req ? AW'(1) : '0;
        else if (clr_idx == LAST_IDX)   clr_idx <= '0;
        else                            clr_idx <= clr_idx + AW'(1);
    end

    // Storage and scoreboard update. Higher write ports are assigned later,
    // so they win a collision. Alloc is applied after all writes, so it wins
    // the pend bit over a write to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
            pend <= '0;
        end else if (clr_busy) begin
            regs[clr_idx] <= '0;
            pend[clr_idx] <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wa[j] != '0) begin
                    regs[wa[j]] <= wd[j];
                    pend[wa[j]] <= 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) pend[alloc_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [XLEN-1:0] data;
        logic            pnd;

        // Read port: stored value, optional forwarding, then masking for
        // address 0 and for an active clear
        always_comb begin
            data = regs[ra[k]];
            pnd  = pend[ra[k]];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wa[j] == ra[k] && ra[k] != '0) begin
                    data = wd[j];
                    pnd  = alloc_en && (alloc_addr == ra[k]);
                end
            end
`endif
            if (clr_busy || ra[k] == '0) begin
                data = '0;
                pnd  = 1'b0;
            end
        end

        assign rdv[k]     = data;
        assign rd_pend[k] = pnd;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed testbench for multiport_regfile using the default parameters.
// It follows whichever build of MULTIPORT_REGFILE_BYPASS_EN is compiled.
module tb_multiport_regfile;

    localparam int XLEN = 64;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pend;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*XLEN-1:0] wr_data = '0;
    logic                alloc_en = 1'b0;
    logic [AW-1:0]       alloc_addr = '0;
    logic                clr_req = 1'b0;
    logic                clr_busy;

    int total = 0;
    int pass  = 0;
    int cnt;

    multiport_regfile dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
        wr_en[j]            = en;
        wr_addr[j*AW +: AW] = a;
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] rdp(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] fill_val(input int i);
        return {32'hA5A5_0000 + 32'(i), 32'h0000_0001};
    endfunction

    initial begin
        // Reset state
        step; step;
        set_rd(0, 5'd1); set_rd(1, 5'd31);
        #1;
        chk("rst_rd0", rdp(0), 64'h0);
        chk("rst_rd1", rdp(1), 64'h0);
        chk("rst_pend", 64'(rd_pend), 64'h0);
        chk("rst_busy", 64'(clr_busy), 64'h0);
        rst = 1'b0;
        step;

        // Basic write/read and x0 hardwired zero
        set_wr(0, 1'b1, 5'd5, 64'h1122334455667788);
        step;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_rd(1, 5'd5);
        #1;
        chk("x5_rd", rdp(1), 64'h1122334455667788);
        set_wr(1, 1'b1, 5'd0, 64'hFFFF);
        alloc_en = 1'b1; alloc_addr = 5'd0;
        step;
        set_wr(1, 1'b0, 5'd0, 64'h0);
        alloc_en = 1'b0;
        set_rd(0, 5'd0);
        #1;
        chk("x0_rd", rdp(0), 64'h0);
        chk("x0_pend", 64'(rd_pend[0]), 64'h0);

        // Write collision: highest port wins
        set_wr(0, 1'b1, 5'd7, 64'hA);
        set_wr(1, 1'b1, 5'd7, 64'hB);
        step;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_wr(1, 1'b0, 5'd0, 64'h0);
        set_rd(0, 5'd7);
        #1;
        chk("x7_collide", rdp(0), 64'hB);

        // Scoreboard: alloc, write clears, alloc beats write
        alloc_en = 1'b1; alloc_addr = 5'd9;
        step;
        alloc_en = 1'b0;
        set_rd(0, 5'd9);
        #1;
        chk("x9_alloc_pend", 64'(rd_pend[0]), 64'h1);
        set_wr(1, 1'b1, 5'd9, 64'h3);
        step;
        set_wr(1, 1'b0, 5'd0, 64'h0);
        #1;
        chk("x9_wr_pend", 64'(rd_pend[0]), 64'h0);
        chk("x9_wr_data", rdp(0), 64'h3);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        set_wr(0, 1'b1, 5'd9, 64'h3);
        step;
        alloc_en = 1'b0;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("x9_both_pend", 64'(rd_pend[0]), 64'h1);
        chk("x9_both_data", rdp(0), 64'h3);

        // Same-cycle read of a register being written
        set_wr(0, 1'b1, 5'd3, 64'h55);
        set_rd(1, 5'd3);
        #1;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
        chk("x3_same_cycle", rdp(1), 64'h55);
        chk("x3_same_pend", 64'(rd_pend[1]), 64'h0);
`else
        chk("x3_same_cycle", rdp(1), 64'h0);
        chk("x3_same_pend", 64'(rd_pend[1]), 64'h0);
`endif
        step;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        #1;
        chk("x3_after", rdp(1), 64'h55);

        // Fill x1..x31, two registers per cycle
        for (int i = 1; i < 32; i += 2) begin
            set_wr(0, 1'b1, 5'(i), fill_val(i));
            if (i + 1 < 32) set_wr(1, 1'b1, 5'(i + 1), fill_val(i + 1));
            else            set_wr(1, 1'b0, 5'd0, 64'h0);
            step;
        end
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_wr(1, 1'b0, 5'd0, 64'h0);
        alloc_en = 1'b1; alloc_addr = 5'd31;
        step;
        alloc_en = 1'b0;
        set_rd(0, 5'd31); set_rd(1, 5'd31);
        #1;
        chk("x31_fill", rdp(0), fill_val(31));
        chk("x31_pend", 64'(rd_pend[1]), 64'h1);

        // Sequential clear
        clr_req = 1'b1;
        step;
        clr_req = 1'b0;
        #1;
        chk("clr_busy_on", 64'(clr_busy), 64'h1);
        chk("clr_rd_masked", rdp(0), 64'h0);
        chk("clr_pend_masked", 64'(rd_pend[1]), 64'h0);
        cnt = 0;
        while (clr_busy === 1'b1 && cnt < 100) begin
            if (cnt == 5) set_wr(0, 1'b1, 5'd2, 64'hDEAD);
            else          set_wr(0, 1'b0, 5'd0, 64'h0);
            if (cnt == 6) begin
                alloc_en = 1'b1; alloc_addr = 5'd2;
            end else begin
                alloc_en = 1'b0;
            end
            cnt++;
            step;
        end
        set_wr(0, 1'b0, 5'd0, 64'h0);
        alloc_en = 1'b0;
        chk("clr_cycles", 64'(cnt), 64'd31);
        for (int i = 1; i < 32; i++) begin
            set_rd(0, 5'(i));
            #1;
            chk($sformatf("clr_x%0d", i), rdp(0), 64'h0);
        end
        set_rd(1, 5'd2);
        #1;
        chk("clr_x2_pend", 64'(rd_pend[1]), 64'h0);
        set_rd(1, 5'd31);
        #1;
        chk("clr_x31_pend", 64'(rd_pend[1]), 64'h0);

        // Reset during a clear aborts it
        set_wr(0, 1'b1, 5'd20, 64'h20);
        step;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_rd(0, 5'd20);
        #1;
        chk("x20_fill", rdp(0), 64'h20);
        clr_req = 1'b1;
        step;
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) step;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(clr_busy), 64'h0);
        chk("abort_x20", rdp(0), 64'h0);
        step;
        rst = 1'b0;
        step; step;
        chk("abort_busy_after", 64'(clr_busy), 64'h0);
        set_wr(0, 1'b1, 5'd25, 64'h77);
        step;
        set_wr(0, 1'b0, 5'd0, 64'h0);
        set_rd(0, 5'd25);
        #1;
        chk("abort_wr_ok", rdp(0), 64'h77);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
